// File: rtl/vga_pkg.sv
// Shared types and video timing constants for the VGA memory arbiter slice.
// Purely declarative: no latency, no flow control.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int H_TOTAL  = 800;
   localparam int V_TOTAL  = 525;

   typedef enum logic [1:0] {
      IDLE,
      RD_DATA,
      ACK_GAP
   } arb_state_t;

   typedef enum logic {
      OWN_DISP,
      OWN_CPU
   } rd_owner_t;

endpackage

// File: rtl/vga_sel_sync.sv
// Frame-synchronous image buffer select: image_select follows sel_req only on frame_end.
// Select updates one clk after frame_end; no backpressure, sel_pending is combinational.
module vga_sel_sync (
   input  logic clk,
   input  logic reset,
   input  logic frame_end,
   input  logic sel_req,
   output logic image_select,
   output logic sel_pending
);

   always_ff @(posedge clk) begin
      if (reset) begin
         image_select <= 1'b0;
      end else if (frame_end) begin
         image_select <= sel_req;
      end
   end

   assign sel_pending = sel_req != image_select;

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port video RAM arbiter: display fetch owns pix_en&&active slots, CPU gets the rest.
// Display data 1 clk after issue; CPU waits (req held) until ack, write ack same clk, read ack 1 clk later.
module vga_mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_en,
   input  logic              active,
   input  logic              frame_end,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              sel_req,
   output logic              image_select,
   output logic              sel_pending,
   output logic              cpu_starved,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   import vga_pkg::*;

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   arb_state_t        state;
   rd_owner_t         rd_owner;
   logic              rd_vld;
   logic [CNT_W-1:0]  wait_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              disp_slot;
   logic              cpu_slot;
   logic              cpu_wr;
   logic              cpu_rd;
   logic              cpu_waiting;

   always_comb begin
      disp_slot   = pix_en && active;
      cpu_slot    = !disp_slot && (state == IDLE) && cpu_req;
      cpu_wr      = cpu_slot && cpu_we;
      cpu_rd      = cpu_slot && !cpu_we;
      cpu_waiting = (state == IDLE) && cpu_req && !cpu_slot;
   end

   // Everything visible is gated by reset so an in-flight read or a pending write dies in the reset cycle.
   always_comb begin
      mem_we     = !reset && cpu_wr;
      mem_wdata  = reset ? '0 : (cpu_wr ? cpu_wdata : wdata_q);
      disp_valid = !reset && rd_vld && (rd_owner == OWN_DISP);
      disp_data  = disp_valid ? mem_rdata : '0;
      cpu_ack    = !reset && ((state == RD_DATA) || cpu_wr);
      cpu_rdata  = (!reset && rd_vld && (rd_owner == OWN_CPU)) ? mem_rdata : '0;
      if (reset)          mem_addr = '0;
      else if (disp_slot) mem_addr = disp_addr;
      else if (cpu_slot)  mem_addr = cpu_addr;
      else                mem_addr = addr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rd_vld      <= 1'b0;
         rd_owner    <= OWN_DISP;
         wait_cnt    <= '0;
         cpu_starved <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         // Tag each issued read so the returning data lands on exactly one path.
         rd_vld   <= disp_slot || cpu_rd;
         rd_owner <= disp_slot ? OWN_DISP : OWN_CPU;
         if (disp_slot || cpu_slot) addr_q <= mem_addr;
         if (cpu_wr) wdata_q <= cpu_wdata;

         case (state)
            IDLE: begin
               if (cpu_wr)      state <= ACK_GAP;
               else if (cpu_rd) state <= RD_DATA;
            end
            RD_DATA: state <= ACK_GAP;
            ACK_GAP: state <= IDLE;
            default: state <= IDLE;
         endcase

         if (cpu_ack) begin
            wait_cnt <= '0;
         end else if (cpu_waiting && (wait_cnt != CNT_W'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (cpu_waiting && (wait_cnt >= CNT_W'(MAX_WAIT - 1))) cpu_starved <= 1'b1;
      end
   end

   vga_sel_sync u_sel_sync (
      .clk          (clk),
      .reset        (reset),
      .frame_end    (frame_end),
      .sel_req      (sel_req),
      .image_select (image_select),
      .sel_pending  (sel_pending)
   );

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter with a small behavioural RAM (1-clk read latency).
// Stimulus pushes expected display/CPU responses; a negedge monitor pops them on disp_valid/cpu_ack.
module tb_vga_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 8;

   typedef struct {
      logic       is_rd;
      logic [7:0] data;
   } cpu_exp_t;

   logic              clk;
   logic              reset;
   logic              pix_en;
   logic              active;
   logic              frame_end;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              sel_req;
   logic              image_select;
   logic              sel_pending;
   logic              cpu_starved;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic [7:0] ram [0:4095];
   logic [7:0] exp_disp[$];
   cpu_exp_t   exp_cpu[$];
   int         n_vec = 0;
   int         n_err = 0;

   vga_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .pix_en       (pix_en),
      .active       (active),
      .frame_end    (frame_end),
      .disp_addr    (disp_addr),
      .disp_data    (disp_data),
      .disp_valid   (disp_valid),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_ack      (cpu_ack),
      .cpu_rdata    (cpu_rdata),
      .sel_req      (sel_req),
      .image_select (image_select),
      .sel_pending  (sel_pending),
      .cpu_starved  (cpu_starved),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Preload is re-applied on every reset; 0x200 is only ever written by the CPU.
   always @(posedge clk) begin
      if (reset) begin
         ram[12'h100] <= 8'h5A;
         ram[12'h300] <= 8'h11;
      end else if (mem_we) begin
         ram[mem_addr[11:0]] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr[11:0]];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Start a cycle just after posedge; a display slot always fetches 0x100 (=0x5A).
   task automatic cyc(input logic pe, input logic act);
      @(posedge clk);
      #1;
      pix_en = pe;
      active = act;
      if (pe && act) exp_disp.push_back(8'h5A);
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push_cpu(input logic rd, input logic [7:0] d);
      cpu_exp_t e;
      e.is_rd = rd;
      e.data  = d;
      exp_cpu.push_back(e);
   endtask

   always @(negedge clk) begin
      if (disp_valid) begin
         if (exp_disp.size() == 0) chk("disp_unexpected", 32'd1, 32'd0);
         else chk("disp_data", 32'(disp_data), 32'(exp_disp.pop_front()));
      end
      if (cpu_ack) begin
         if (exp_cpu.size() == 0) begin
            chk("cpu_ack_unexpected", 32'd1, 32'd0);
         end else begin
            cpu_exp_t e;
            e = exp_cpu.pop_front();
            if (e.is_rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
            else         chk("cpu_wr_ack_we", 32'(mem_we), 32'd1);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; pix_en = 1'b0; active = 1'b1; frame_end = 1'b0;
      disp_addr = 32'h100; cpu_req = 1'b1; cpu_we = 1'b1;
      cpu_addr = 32'h200; cpu_wdata = 8'hC3; sel_req = 1'b0;

      // Reset held 3 clks with a pending CPU write.
      for (int r = 0; r < 3; r++) begin
         cyc(0, 1); smp();
         chk("rst_mem_we", 32'(mem_we), 0);
         chk("rst_cpu_ack", 32'(cpu_ack), 0);
         chk("rst_mem_addr", mem_addr, 0);
      end
      chk("rst_disp_valid", 32'(disp_valid), 0);
      chk("rst_image_select", 32'(image_select), 0);
      chk("rst_sel_pending", 32'(sel_pending), 0);
      chk("rst_starved", 32'(cpu_starved), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);

      // Display slot beats the waiting CPU write.
      cyc(1, 1); reset = 1'b0; smp();
      chk("disp_issue_addr", mem_addr, 32'h100);
      chk("disp_slot_no_we", 32'(mem_we), 0);
      chk("disp_slot_no_ack", 32'(cpu_ack), 0);
      cyc(0, 1); push_cpu(0, 8'h00); smp();
      chk("wr_mem_we", 32'(mem_we), 1);
      chk("wr_mem_addr", mem_addr, 32'h200);
      chk("wr_mem_wdata", 32'(mem_wdata), 32'hC3);
      chk("disp_valid_lat1", 32'(disp_valid), 1);
      cyc(1, 1); cpu_req = 1'b0; smp();
      chk("gap_disp_addr", mem_addr, 32'h100);
      cyc(0, 1); smp();
      chk("idle_no_we", 32'(mem_we), 0);
      chk("idle_addr_hold", mem_addr, 32'h100);

      // Readback of 0x200, display read issued during RD_DATA.
      cyc(1, 1); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200; smp();
      cyc(0, 1); push_cpu(1, 8'hC3); smp();
      chk("rd_issue_addr", mem_addr, 32'h200);
      chk("rd_issue_we", 32'(mem_we), 0);
      cyc(1, 1); smp();
      chk("rd_ack", 32'(cpu_ack), 1);
      chk("rd_no_disp_valid", 32'(disp_valid), 0);
      chk("rd_disp_addr", mem_addr, 32'h100);
      cyc(0, 1); cpu_req = 1'b0; smp();
      chk("rd_ack_once", 32'(cpu_ack), 0);
      chk("rd_then_disp_valid", 32'(disp_valid), 1);

      // Interleave CPU read of 0x300 with a display fetch.
      cyc(1, 1); cpu_req = 1'b1; cpu_addr = 32'h300; smp();
      cyc(0, 1); push_cpu(1, 8'h11); smp();
      chk("il_rd_addr", mem_addr, 32'h300);
      cyc(1, 1); smp();
      cyc(0, 1); cpu_req = 1'b0; smp();
      chk("il_cpu_rdata_idle", 32'(cpu_rdata), 0);

      // Request dropped before service: no RAM access.
      cyc(1, 1); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h400; cpu_wdata = 8'hEE; smp();
      cyc(0, 1); cpu_req = 1'b0; smp();
      chk("abandon_no_we", 32'(mem_we), 0);

      // pix_en outside the active region is a free CPU slot.
      cyc(1, 0); cpu_req = 1'b1; cpu_addr = 32'h500; cpu_wdata = 8'h77; push_cpu(0, 8'h00); smp();
      chk("inactive_we", 32'(mem_we), 1);
      chk("inactive_addr", mem_addr, 32'h500);
      cyc(0, 1); cpu_req = 1'b0; smp();
      chk("inactive_ack_once", 32'(cpu_ack), 0);

      // Buffer select only moves on frame_end.
      cyc(0, 1); sel_req = 1'b1; smp();
      chk("sel_mid_frame", 32'(image_select), 0);
      chk("sel_pending_set", 32'(sel_pending), 1);
      cyc(0, 1); frame_end = 1'b1; smp();
      chk("sel_on_fe", 32'(image_select), 0);
      cyc(0, 1); frame_end = 1'b0; smp();
      chk("sel_after_fe", 32'(image_select), 1);
      chk("sel_pending_clr", 32'(sel_pending), 0);
      cyc(1, 1); sel_req = 1'b0; frame_end = 1'b1; smp();
      chk("sel_fe_disp_old", 32'(image_select), 1);
      cyc(0, 1); frame_end = 1'b0; smp();
      chk("sel_fe_disp_new", 32'(image_select), 0);
      cyc(0, 1); sel_req = 1'b1; smp();
      cyc(0, 1); sel_req = 1'b0; smp();
      cyc(0, 1); frame_end = 1'b1; smp();
      cyc(0, 1); frame_end = 1'b0; smp();
      chk("sel_double_toggle", 32'(image_select), 0);
      chk("sel_double_pending", 32'(sel_pending), 0);

      // Reset while a CPU read is in RD_DATA: no ack, no write.
      cyc(0, 1); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300; smp();
      chk("mid_rd_addr", mem_addr, 32'h300);
      cyc(0, 1); reset = 1'b1; cpu_we = 1'b1; smp();
      chk("mid_rst_no_ack", 32'(cpu_ack), 0);
      chk("mid_rst_no_we", 32'(mem_we), 0);
      cyc(0, 1); smp();
      chk("mid_rst_wr_suppr", 32'(mem_we), 0);

      // Starvation with MAX_WAIT=4 and a display slot every cycle.
      cyc(1, 1); reset = 1'b0; cpu_addr = 32'h600; cpu_wdata = 8'h99; smp();
      for (int k = 0; k < 3; k++) begin
         chk("starve_not_yet", 32'(cpu_starved), 0);
         cyc(1, 1); smp();
      end
      chk("starve_not_yet", 32'(cpu_starved), 0);
      cyc(1, 1); cpu_req = 1'b0; smp();
      chk("starved_set", 32'(cpu_starved), 1);
      cyc(1, 1); smp();
      chk("starved_sticky", 32'(cpu_starved), 1);
      cyc(0, 1); smp();
      chk("starved_sticky2", 32'(cpu_starved), 1);
      cyc(0, 1); reset = 1'b1; smp();
      cyc(0, 1); reset = 1'b0; smp();
      chk("starved_rst_clr", 32'(cpu_starved), 0);

      cyc(0, 1); smp();
      cyc(0, 1); smp();
      chk("disp_queue_drained", exp_disp.size(), 0);
      chk("cpu_queue_drained", exp_cpu.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
